// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl
// HUB75 scan sequencer. Kicks the fetch/shift stage for the next bit plane while
// the current plane is shown. It then latches the new plane and reloads the display timer.
// The timer sets the binary-coded-modulation on-time for that plane.

module hub75_scan_ctrl #(
  parameter int ROWS        = 32,
  parameter int BASE_CYCLES = 8,
  parameter int DEAD_CYCLES = 2,
  parameter int LAT_CYCLES  = 1,
  parameter int TW          = 16
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       busy,
  output logic       start,
  output logic [2:0] bit_cnt,
  output logic [5:0] row_cnt,
  output logic [4:0] addr,
  output logic       lat,
  output logic       oe_n,
  output logic       frame_done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] KICK     = 3'd1;
  localparam logic [2:0] SETTLE   = 3'd2;
  localparam logic [2:0] SHIFTING = 3'd3;
  localparam logic [2:0] SYNC     = 3'd4;
  localparam logic [2:0] DEAD     = 3'd5;
  localparam logic [2:0] LATCH    = 3'd6;
  localparam logic [2:0] DRAIN    = 3'd7;

  localparam logic [7:0] SETTLE_LAST = 8'd1;
  localparam logic [7:0] DEAD_LAST   = 8'(DEAD_CYCLES - 1);
  localparam logic [7:0] LAT_LAST    = 8'(LAT_CYCLES - 1);
  localparam logic [5:0] ROW_LAST    = 6'(ROWS - 1);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [7:0]    step_cnt;
  logic [TW-1:0] timer;
  logic [TW-1:0] load_val;
  logic          timer_zero;
  logic          latch_exit;

  assign timer_zero = (timer == '0);
  assign latch_exit = (state == LATCH) && (step_cnt == LAT_LAST);
  assign load_val   = TW'(BASE_CYCLES) << bit_cnt;

  // Next-state decode of the scan sequence
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (enable) next_state = KICK;
      KICK:     next_state = SETTLE;
      SETTLE:   if (step_cnt == SETTLE_LAST) next_state = SHIFTING;
      SHIFTING: if (!busy) next_state = SYNC;
      SYNC:     if (timer_zero) next_state = DEAD;
      DEAD:     if (step_cnt == DEAD_LAST) next_state = LATCH;
      LATCH:    if (step_cnt == LAT_LAST) next_state = enable ? KICK : DRAIN;
      DRAIN:    if (timer_zero) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // State register plus a per-state cycle counter that restarts on every transition
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step_cnt <= '0;
    end else begin
      state    <= next_state;
      step_cnt <= (next_state != state) ? 8'd0 : step_cnt + 8'd1;
    end
  end

  // Registered strobes that line up exactly with the KICK and LATCH states
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      start <= 1'b0;
      lat   <= 1'b0;
    end else begin
      start <= (next_state == KICK);
      lat   <= (next_state == LATCH);
    end
  end

  // Free-running display timer; the panel is lit for exactly as many cycles as were loaded
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      oe_n  <= 1'b1;
    end else begin
      oe_n <= timer_zero;
      if (latch_exit) begin
        timer <= load_val;
      end else if (!timer_zero) begin
        timer <= timer - 1'b1;
      end
    end
  end

  // Plane/row bookkeeping and the displayed address, all advanced when a latch completes
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      row_cnt    <= '0;
      addr       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (latch_exit) begin
        addr    <= row_cnt[4:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (row_cnt == ROW_LAST) begin
            row_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 6'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl
// Directed bench for the HUB75 scan sequencer, with BASE_CYCLES=4, DEAD_CYCLES=2 and LAT_CYCLES=1.
// A small model of the fetch/shift stage holds busy high for busy_len cycles after each start.

module tb_hub75_scan_ctrl;

  localparam int ROWS = 32;
  localparam int BASE = 4;
  localparam int DEAD = 2;
  localparam int LATW = 1;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       busy;
  logic       start;
  logic [2:0] bit_cnt;
  logic [5:0] row_cnt;
  logic [4:0] addr;
  logic       lat;
  logic       oe_n;
  logic       frame_done;

  int vectors     = 0;
  int miscompares = 0;
  int busy_len    = 5;
  int busy_left;
  int fd_count    = 0;

  hub75_scan_ctrl #(
    .ROWS(ROWS), .BASE_CYCLES(BASE), .DEAD_CYCLES(DEAD), .LAT_CYCLES(LATW), .TW(16)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .busy(busy), .start(start),
    .bit_cnt(bit_cnt), .row_cnt(row_cnt), .addr(addr), .lat(lat), .oe_n(oe_n),
    .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Fetch/shift stage model: busy for busy_len cycles following each start pulse
  always @(posedge sys_clk or posedge rst) begin
    if (rst) busy_left <= 0;
    else if (start) busy_left <= busy_len;
    else if (busy_left != 0) busy_left <= busy_left - 1;
  end
  assign busy = (busy_left != 0);

  // Panel-safety invariants and frame_done pulse counting, every cycle out of reset
  always @(negedge sys_clk) begin
    if (rst === 1'b0) begin
      vectors++;
      if ((lat === 1'b1 && oe_n === 1'b0) || (start === 1'b1 && busy === 1'b1)) begin
        miscompares++;
        $display("[TB] FAIL invariant: lat=%b oe_n=%b start=%b busy=%b, required no lat with oe_n=0 and no start with busy=1",
                 lat, oe_n, start, busy);
      end
      if (frame_done === 1'b1) fd_count++;
    end
  end

  function automatic logic sig_val(input int which);
    case (which)
      0: return start;
      1: return lat;
      2: return oe_n;
      default: return busy;
    endcase
  endfunction

  // Advance on falling edges until the selected signal reaches level; a timeout is a failure
  task automatic wait_sig(input string name, input int which, input logic level,
                          input int bound, output int cycles);
    cycles = 0;
    while (sig_val(which) !== level && cycles < bound) begin
      @(negedge sys_clk);
      cycles++;
    end
    if (sig_val(which) !== level) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL timeout_%s: still %b after %0d cycles, required %b", name, sig_val(which), cycles, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    #1;
    vectors++;
    if (oe_n !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_oe_n: got %b, required 1", oe_n);
    end
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      vectors++;
      if (start !== 1'b0 || lat !== 1'b0 || oe_n !== 1'b1 || addr !== 5'd0 ||
          bit_cnt !== 3'd0 || row_cnt !== 6'd0 || frame_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_hold cycle %0d: start=%b lat=%b oe_n=%b addr=%0d bit=%0d row=%0d fd=%b, required 0 0 1 0 0 0 0",
                 i, start, lat, oe_n, addr, bit_cnt, row_cnt, frame_done);
      end
    end
  endtask

  task automatic test_first_plane();
    int n;
    int low;
    bit addr_ok;
    busy_len = 5;
    enable = 1'b1;
    wait_sig("start0", 0, 1'b1, 20, n);
    vectors++;
    if (bit_cnt !== 3'd0 || row_cnt !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL first_start: bit=%0d row=%0d, required 0 0", bit_cnt, row_cnt);
    end
    wait_sig("busy_hi", 3, 1'b1, 10, n);
    wait_sig("busy_lo", 3, 1'b0, 20, n);
    // SHIFTING sees busy low, one SYNC cycle (timer already 0), then DEAD cycles
    wait_sig("lat1", 1, 1'b1, 50, n);
    vectors++;
    if (n != 2 + DEAD) begin
      miscompares++;
      $display("[TB] FAIL first_lat_delay: got %0d cycles after busy fell, required %0d", n, 2 + DEAD);
    end
    wait_sig("lat1_lo", 1, 1'b0, 10, n);
    vectors++;
    if (start !== 1'b1 || bit_cnt !== 3'd1 || addr !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL second_start: start=%b bit=%0d addr=%0d, required 1 1 0", start, bit_cnt, addr);
    end
    wait_sig("oe_lo", 2, 1'b0, 10, n);
    low = 0;
    addr_ok = 1'b1;
    while (oe_n === 1'b0 && low < 100) begin
      if (addr !== 5'd0) addr_ok = 1'b0;
      low++;
      @(negedge sys_clk);
    end
    vectors++;
    if (low != BASE || !addr_ok) begin
      miscompares++;
      $display("[TB] FAIL plane0_on_time: oe_n low %0d cycles addr_ok=%b, required %0d and 1", low, addr_ok, BASE);
    end
  endtask

  task automatic test_plane3();
    int n;
    int low;
    busy_len = 3;
    n = 0;
    while (!(lat === 1'b1 && bit_cnt === 3'd3) && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    vectors++;
    if (!(lat === 1'b1 && bit_cnt === 3'd3)) begin
      miscompares++;
      $display("[TB] FAIL plane3_lat: never latched plane 3, bit=%0d lat=%b", bit_cnt, lat);
    end
    wait_sig("lat3_lo", 1, 1'b0, 10, n);
    wait_sig("oe3_lo", 2, 1'b0, 10, n);
    low = 0;
    while (oe_n === 1'b0 && low < 200) begin
      low++;
      @(negedge sys_clk);
    end
    vectors++;
    if (low != (BASE << 3)) begin
      miscompares++;
      $display("[TB] FAIL plane3_on_time: oe_n low %0d cycles, required %0d", low, BASE << 3);
    end
    wait_sig("lat4", 1, 1'b1, 50, n);
    vectors++;
    if (n != DEAD || bit_cnt !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL plane4_lat_delay: %0d cycles after oe_n rose bit=%0d, required %0d and 4", n, bit_cnt, DEAD);
    end
  endtask

  task automatic test_slow_busy();
    int n;
    busy_len = 200;
    n = 0;
    while (!(lat === 1'b1 && bit_cnt === 3'd7) && n < 6000) begin
      @(negedge sys_clk);
      n++;
    end
    vectors++;
    if (!(lat === 1'b1 && bit_cnt === 3'd7)) begin
      miscompares++;
      $display("[TB] FAIL plane7_lat: never latched plane 7, bit=%0d lat=%b", bit_cnt, lat);
    end
    wait_sig("lat7_lo", 1, 1'b0, 10, n);
    wait_sig("oe7_lo", 2, 1'b0, 10, n);
    wait_sig("oe7_hi", 2, 1'b1, 600, n);
    vectors++;
    if (busy !== 1'b0 || n != (BASE << 7)) begin
      miscompares++;
      $display("[TB] FAIL plane7_display: busy=%b on_time=%0d, required 0 and %0d", busy, n, BASE << 7);
    end
    wait_sig("lat_after7", 1, 1'b1, 50, n);
    vectors++;
    if (n != DEAD || bit_cnt !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL timer_later_lat: %0d cycles after oe_n rose bit=%0d, required %0d and 0", n, bit_cnt, DEAD);
    end
    wait_sig("lat0_lo", 1, 1'b0, 10, n);
    wait_sig("busy1_hi", 3, 1'b1, 10, n);
    wait_sig("busy1_lo", 3, 1'b0, 300, n);
    vectors++;
    if (oe_n !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL plane0_expired: oe_n=%b when busy fell, required 1", oe_n);
    end
    wait_sig("lat_busy_later", 1, 1'b1, 50, n);
    vectors++;
    if (n != 2 + DEAD || bit_cnt !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL busy_later_lat: %0d cycles after busy fell bit=%0d, required %0d and 1", n, bit_cnt, 2 + DEAD);
    end
  endtask

  task automatic test_frame();
    int n;
    enable = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    fd_count = 0;
    busy_len = 3;
    enable = 1'b1;
    for (int i = 0; i < 8 * ROWS; i++) begin
      wait_sig("frame_lat", 1, 1'b1, 3000, n);
      vectors++;
      if (bit_cnt !== 3'(i % 8) || row_cnt !== 6'(i / 8)) begin
        miscompares++;
        $display("[TB] FAIL frame_counters latch %0d: bit=%0d row=%0d, required %0d %0d", i, bit_cnt, row_cnt, i % 8, i / 8);
      end
      wait_sig("frame_lat_lo", 1, 1'b0, 10, n);
      vectors++;
      if (addr !== 5'(i / 8) || frame_done !== (i == 8 * ROWS - 1)) begin
        miscompares++;
        $display("[TB] FAIL frame_addr latch %0d: addr=%0d fd=%b, required %0d %b", i, addr, frame_done, i / 8, i == 8 * ROWS - 1);
      end
    end
    vectors++;
    if (bit_cnt !== 3'd0 || row_cnt !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL frame_wrap: bit=%0d row=%0d, required 0 0", bit_cnt, row_cnt);
    end
    repeat (2) @(negedge sys_clk);
    vectors++;
    if (fd_count != 1) begin
      miscompares++;
      $display("[TB] FAIL frame_done_pulses: got %0d, required 1", fd_count);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    wait_sig("mr_lat_a", 1, 1'b1, 3000, n);
    wait_sig("mr_lat_a_lo", 1, 1'b0, 10, n);
    wait_sig("mr_lat_b", 1, 1'b1, 3000, n);
    wait_sig("mr_lat_b_lo", 1, 1'b0, 10, n);
    wait_sig("mr_oe_lo", 2, 1'b0, 20, n);
    rst = 1'b1;
    #1;
    vectors++;
    if (oe_n !== 1'b1 || lat !== 1'b0 || start !== 1'b0 || bit_cnt !== 3'd0 ||
        row_cnt !== 6'd0 || addr !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: oe_n=%b lat=%b start=%b bit=%0d row=%0d addr=%0d, required 1 0 0 0 0 0",
               oe_n, lat, start, bit_cnt, row_cnt, addr);
    end
    @(negedge sys_clk);
    rst = 1'b0;
    wait_sig("restart", 0, 1'b1, 20, n);
    vectors++;
    if (bit_cnt !== 3'd0 || row_cnt !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL restart_counters: bit=%0d row=%0d, required 0 0", bit_cnt, row_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_plane();
    test_plane3();
    test_slow_busy();
    test_frame();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
